mem_bank_responder: RTL and testbench

- Memory-side responder for the control unit's memory-bank interface.
- Owns a 256x16 synchronous RAM.
- Loads a program image over a streaming loader port after reset.
- Services instruction fetches (PC address) and data reads/writes (datapath address) with fixed 1-cycle read latency.
- Sits between the control unit, the datapath (write data) and the board-level program loader.

---
 rtl/mb_pkg.sv | 17 +
 rtl/mb_ram.sv | 22 ++
 rtl/mem_bank_responder.sv | 138 +++++++++++++
 tb/tb_mem_bank_responder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mb_pkg.sv
// Shared constants, selector encodings and FSM state type for the memory-bank responder.
package mb_pkg;

  localparam int unsigned MB_DATA_W = 16;
  localparam int unsigned MB_ADDR_W = 8;
  localparam int unsigned MB_DEPTH  = 256;

  localparam logic MB_SEL_PC   = 1'b0;
  localparam logic MB_SEL_DATA = 1'b1;

  typedef enum logic [1:0] {
    MB_CLEAR,
    MB_LOAD,
    MB_RUN
  } mb_state_t;

endpackage

// File: rtl/mb_ram.sv
// Single-port synchronous RAM, registered read, read-first on a same-cycle write.
module mb_ram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_bank_responder.sv
// Memory-bank responder: clears RAM, loads a program image, then serves fetch/data accesses.
// Optional build macro: MB_WRITE_PROTECT_EN (drops RUN data writes at or below PROT_TOP).
module mem_bank_responder
  import mb_pkg::*;
#(
  parameter int unsigned DATA_W = MB_DATA_W,
  parameter int unsigned ADDR_W = MB_ADDR_W,
  parameter int unsigned DEPTH  = MB_DEPTH,
  parameter logic [ADDR_W-1:0] PROT_TOP = ADDR_W'(8'h7F)
) (
  input  logic              CLK100MHZ,
  input  logic              rst_n,
  input  logic              mb_sel,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic [ADDR_W-1:0] mb_addr,
  input  logic              mb_read,
  input  logic              mb_write,
  input  logic [DATA_W-1:0] mb_data_in,
  output logic [DATA_W-1:0] mb_data_out,
  output logic              mb_data_valid,
  output logic              mb_busy,
  output logic              mb_wr_err,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready
);

  localparam int unsigned PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
`ifdef MB_WRITE_PROTECT_EN
  localparam bit PROT_ON = 1'b1;
`else
  localparam bit PROT_ON = 1'b0;
`endif

  mb_state_t         state_q, state_d;
  logic [PTR_W-1:0]  clr_ptr_q, clr_ptr_d;
  logic [PTR_W-1:0]  ld_ptr_q, ld_ptr_d;
  logic              rd_pend_q;
  logic              rd_req, wr_err_d, busy_d, ld_ready_d;
  logic              prot_hit;
  logic [ADDR_W-1:0] eff_addr;
  logic              ram_we_c;
  logic [ADDR_W-1:0] ram_addr_c;
  logic [DATA_W-1:0] ram_wdata_c;
  logic [DATA_W-1:0] ram_rdata;

  assign eff_addr = (mb_sel == MB_SEL_DATA) ? mb_addr : pc_addr;
  assign prot_hit = PROT_ON && (mb_addr <= PROT_TOP);

  // State register
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) state_q <= MB_CLEAR;
    else        state_q <= state_d;
  end

  // Next state, RAM port muxing and request decode
  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    ld_ptr_d    = ld_ptr_q;
    ram_we_c    = 1'b0;
    ram_addr_c  = eff_addr;
    ram_wdata_c = '0;
    rd_req      = 1'b0;
    wr_err_d    = 1'b0;
    case (state_q)
      MB_CLEAR: begin
        ram_we_c   = 1'b1;
        ram_addr_c = clr_ptr_q[ADDR_W-1:0];
        clr_ptr_d  = clr_ptr_q + PTR_W'(1);
        if (clr_ptr_q == PTR_LAST) state_d = MB_LOAD;
      end
      MB_LOAD: begin
        if (ld_valid) begin
          ram_we_c    = 1'b1;
          ram_addr_c  = ld_ptr_q[ADDR_W-1:0];
          ram_wdata_c = ld_data;
          ld_ptr_d    = ld_ptr_q + PTR_W'(1);
          if (ld_last || (ld_ptr_q == PTR_LAST)) state_d = MB_RUN;
        end
      end
      MB_RUN: begin
        // Write wins over a simultaneous read; fetch-path writes are rejected.
        if (mb_write) begin
          if ((mb_sel == MB_SEL_DATA) && !prot_hit) begin
            ram_we_c    = 1'b1;
            ram_wdata_c = mb_data_in;
          end else begin
            wr_err_d = 1'b1;
          end
        end else if (mb_read) begin
          rd_req = 1'b1;
        end
      end
      default: state_d = MB_CLEAR;
    endcase
    busy_d     = (state_d != MB_RUN);
    ld_ready_d = (state_d == MB_LOAD);
  end

  // Pointers and registered outputs
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      clr_ptr_q     <= '0;
      ld_ptr_q      <= '0;
      rd_pend_q     <= 1'b0;
      mb_data_out   <= '0;
      mb_data_valid <= 1'b0;
      mb_wr_err     <= 1'b0;
      mb_busy       <= 1'b1;
      ld_ready      <= 1'b0;
    end else begin
      clr_ptr_q     <= clr_ptr_d;
      ld_ptr_q      <= ld_ptr_d;
      rd_pend_q     <= rd_req;
      mb_data_valid <= rd_pend_q;
      if (rd_pend_q) mb_data_out <= ram_rdata;
      mb_wr_err     <= wr_err_d;
      mb_busy       <= busy_d;
      ld_ready      <= ld_ready_d;
    end
  end

  // Gate the write with reset so nothing commits while reset is held.
  mb_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (CLK100MHZ),
    .we   (ram_we_c & rst_n),
    .addr (ram_addr_c),
    .wdata(ram_wdata_c),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_mem_bank_responder.sv
// Directed self-checking bench for mem_bank_responder.
module tb_mem_bank_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mb_sel;
  logic [7:0]  pc_addr, mb_addr;
  logic        mb_read, mb_write;
  logic [15:0] mb_data_in, mb_data_out;
  logic        mb_data_valid, mb_busy, mb_wr_err;
  logic        ld_valid, ld_last, ld_ready;
  logic [15:0] ld_data;

  int total = 0;
  int bad   = 0;
  int cnt;
  logic [15:0] img [4];
  logic [15:0] exp_prot_rd;
  logic        exp_prot_err;

  always #5 clk = ~clk;

  mem_bank_responder dut (
    .CLK100MHZ    (clk),
    .rst_n        (rst_n),
    .mb_sel       (mb_sel),
    .pc_addr      (pc_addr),
    .mb_addr      (mb_addr),
    .mb_read      (mb_read),
    .mb_write     (mb_write),
    .mb_data_in   (mb_data_in),
    .mb_data_out  (mb_data_out),
    .mb_data_valid(mb_data_valid),
    .mb_busy      (mb_busy),
    .mb_wr_err    (mb_wr_err),
    .ld_valid     (ld_valid),
    .ld_data      (ld_data),
    .ld_last      (ld_last),
    .ld_ready     (ld_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Read with 1-cycle latency: valid low after the request edge, high one edge later, then low.
  task automatic rd(input string tag, input logic sel, input logic [7:0] a, input logic [15:0] exp);
    mb_sel = sel;
    if (sel) mb_addr = a; else pc_addr = a;
    mb_read = 1'b1;
    tick();
    mb_read = 1'b0;
    chk({tag, "_vlo"}, 16'(mb_data_valid), 16'h0);
    tick();
    chk({tag, "_vhi"}, 16'(mb_data_valid), 16'h1);
    chk({tag, "_dat"}, mb_data_out, exp);
    tick();
    chk({tag, "_vpulse"}, 16'(mb_data_valid), 16'h0);
  endtask

  // Count cycles from reset release until ld_ready rises (bounded).
  task automatic wait_clear(input string tag);
    cnt = 0;
    while (!ld_ready && cnt < 1000) begin
      chk({tag, "_busy"}, 16'(mb_busy), 16'h1);
      tick();
      cnt++;
    end
    chk({tag, "_cycles"}, 16'(cnt), 16'd256);
    chk({tag, "_busy_load"}, 16'(mb_busy), 16'h1);
  endtask

  initial begin
    img[0] = 16'h1234; img[1] = 16'hABCD; img[2] = 16'h0001; img[3] = 16'hFFFF;
`ifdef MB_WRITE_PROTECT_EN
    exp_prot_rd = 16'hABCD; exp_prot_err = 1'b1;
`else
    exp_prot_rd = 16'h0000; exp_prot_err = 1'b0;
`endif
    rst_n = 1'b0; mb_sel = 1'b0; pc_addr = '0; mb_addr = '0;
    mb_read = 1'b0; mb_write = 1'b0; mb_data_in = '0;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    #23;
    chk("rst_busy", 16'(mb_busy), 16'h1);
    chk("rst_ready", 16'(ld_ready), 16'h0);
    chk("rst_dout", mb_data_out, 16'h0);
    chk("rst_valid", 16'(mb_data_valid), 16'h0);
    chk("rst_err", 16'(mb_wr_err), 16'h0);

    tick();
    rst_n = 1'b1;
    wait_clear("clr1");

    // Stream the 4-word image
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_data = img[i]; ld_last = (i == 3);
      tick();
      if (i == 2) chk("ld_busy_mid", 16'(mb_busy), 16'h1);
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("ld_busy_done", 16'(mb_busy), 16'h0);
    chk("ld_ready_done", 16'(ld_ready), 16'h0);

    for (int i = 0; i < 4; i++) rd($sformatf("fetch%0d", i), 1'b0, 8'(i), img[i]);
    rd("fetch4", 1'b0, 8'h04, 16'h0000);

    // Write then read-after-write at the same address
    mb_sel = 1'b1; mb_addr = 8'hC0; mb_data_in = 16'hBEEF; mb_write = 1'b1;
    tick();
    mb_write = 1'b0;
    chk("wr_c0_err", 16'(mb_wr_err), 16'h0);
    rd("raw_c0", 1'b1, 8'hC0, 16'hBEEF);

    // Read+write together: write wins, no valid pulse, data holds
    mb_addr = 8'hC1; mb_data_in = 16'h5555; mb_read = 1'b1; mb_write = 1'b1;
    tick();
    mb_read = 1'b0; mb_write = 1'b0;
    tick();
    chk("rw_valid", 16'(mb_data_valid), 16'h0);
    chk("rw_dout_hold", mb_data_out, 16'hBEEF);
    rd("rw_c1", 1'b1, 8'hC1, 16'h5555);

    // Write into the fetch path is rejected
    mb_sel = 1'b0; pc_addr = 8'h02; mb_data_in = 16'h7777; mb_write = 1'b1;
    tick();
    mb_write = 1'b0;
    chk("pcwr_err_hi", 16'(mb_wr_err), 16'h1);
    tick();
    chk("pcwr_err_lo", 16'(mb_wr_err), 16'h0);
    rd("pcwr_rd2", 1'b0, 8'h02, 16'h0001);

    // Write into the low region (protected only when the macro is defined)
    mb_sel = 1'b1; mb_addr = 8'h01; mb_data_in = 16'h0000; mb_write = 1'b1;
    tick();
    mb_write = 1'b0;
    chk("prot_err", 16'(mb_wr_err), 16'(exp_prot_err));
    rd("prot_rd1", 1'b1, 8'h01, exp_prot_rd);

    // Reset mid-RUN: outputs return to reset values at once
    rd("pre_rst", 1'b0, 8'h00, 16'h1234);
    #2 rst_n = 1'b0;
    #1;
    chk("runrst_dout", mb_data_out, 16'h0);
    chk("runrst_busy", 16'(mb_busy), 16'h1);
    tick();
    rst_n = 1'b1;
    wait_clear("clr2");

    // Hold cycle, stray ld_last and a dropped request during LOAD
    ld_last = 1'b1;
    mb_sel = 1'b0; mb_write = 1'b1;
    tick();
    ld_last = 1'b0; mb_write = 1'b0;
    chk("ld_hold_ready", 16'(ld_ready), 16'h1);
    chk("ld_drop_err", 16'(mb_wr_err), 16'h0);
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1; ld_data = 16'hAA01 + 16'(i);
      tick();
    end
    ld_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ldrst_ready", 16'(ld_ready), 16'h0);
    chk("ldrst_busy", 16'(mb_busy), 16'h1);
    tick();
    rst_n = 1'b1;
    wait_clear("clr3");

    ld_valid = 1'b1; ld_data = 16'h4321; ld_last = 1'b1;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("reload_busy", 16'(mb_busy), 16'h0);
    rd("reload_a0", 1'b0, 8'h00, 16'h4321);
    rd("reload_a1", 1'b0, 8'h01, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
